inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
//
// PURPOSE
//   Instruction fetch/issue stage. It produces the 6-bit opcode consumed by the control unit (cu).
//   It holds the PC, reads one instruction word at a time from program memory over a req/ack
//   interface, and presents opcode and operand fields to decode over a valid/ready handshake.
//   It supports PC redirect (branch/jump) and a HALT opcode.
//   Sits between program memory and cu / register-file decode.
//
// PARAMETERS
//   INST_W    16        instruction word width; opcode = inst[INST_W-1 -: 6]
//   PC_W      8         PC / program memory address width
//   RESET_PC  0         PC value loaded on reset
//   HALT_OP   6'b111111 opcode that stops fetching once issued
//
// PORTS
//   clk          in   1         clock, rising edge
//   rst          in   1         reset, asynchronous, active-high
//   run          in   1         level; start fetching from IDLE
//   imem_req     out  1         memory read request, held until imem_ack
//   imem_addr    out  PC_W      read address, stable while imem_req=1
//   imem_ack     in   1         read data valid this cycle (latency >=1 cycle after req)
//   imem_data    in   INST_W    instruction word, sampled when imem_ack=1
//   inst_valid   out  1         opcode/operand/pc_out valid for decode
//   inst_ready   in   1         decode accepts instruction this cycle
//   opcode       out  6         instruction opcode to cu; 6'b000000 (NOP) whenever inst_valid=0
//   operand      out  INST_W-6  remaining instruction bits; 0 whenever inst_valid=0
//   pc_out       out  PC_W      address of the instruction on opcode/operand
//   redirect     in   1         load redirect_pc as next fetch address
//   redirect_pc  in   PC_W      redirect target
//   halted       out  1         HALT issued; fetch stopped
//
// BEHAVIOUR
//   - Reset (async, any state, mid-transaction included): state=IDLE, pc=RESET_PC; all outputs 0.
//     Any in-flight memory read is abandoned and a late imem_ack is ignored.
//   - All outputs are registered.
//   - States: IDLE, FETCH, ISSUE, HALT.
//   - IDLE: run=1 -> FETCH. imem_req=1 and imem_addr=pc from the next cycle.
//   - FETCH: imem_req and imem_addr are held until imem_ack.
//     - On imem_ack in cycle N: latch the word; opcode/operand/pc_out update and inst_valid=1 in N+1.
//     - pc <= pc+1, wrapping modulo 2^PC_W. imem_req=0 from N+1. -> ISSUE.
//   - ISSUE: inst_valid, opcode, operand and pc_out are stable until inst_valid && inst_ready.
//     - On the handshake in cycle M: inst_valid=0 in M+1.
//     - Issued opcode == HALT_OP -> HALT; otherwise -> FETCH, with imem_req=1 in M+1.
//     - Throughput: one instruction per (memory latency + 2) cycles minimum. No prefetch, one outstanding read.
//   - HALT: halted=1 and imem_req=0; leaves only on redirect or rst.
//   - redirect (highest priority after rst):
//     - IDLE: pc <= redirect_pc; stay IDLE.
//     - FETCH, outstanding read: imem_req stays high until imem_ack. The returned word is discarded
//       (never issued). Then a new read at redirect_pc.
//     - FETCH, same cycle as imem_ack: word discarded; next read at redirect_pc.
//     - ISSUE: inst_valid=0 next cycle; pc <= redirect_pc; -> FETCH.
//       If inst_ready is also high that cycle, the instruction counts as consumed,
//       but a HALT_OP issued in that cycle does not halt (redirect wins).
//     - HALT: halted=0, pc <= redirect_pc, -> FETCH.
//     - A redirect during a pending discard replaces the target; only one discard is pending.
//   - run is ignored outside IDLE; deasserting it does not stop fetching.
//
// TESTING
//   1. Reset, run=1, memory latency 1, mem[0..2]={0x3800,0x0000,0x3800}:
//      -> opcodes 001110, 000000, 001110 on pc_out 0,1,2. Each issued 3 cycles apart with inst_ready=1.
//   2. Backpressure: inst_ready=0 for 5 cycles during ISSUE -> opcode/operand/pc_out held; no imem_req asserted.
//   3. Redirect to 0x40 while a read of 0x05 is outstanding (latency 4):
//      -> mem[5] never issued; next imem_addr=0x40; first issued pc_out=0x40.
//   4. mem[3]=HALT_OP<<10: issued at pc_out 3 -> halted=1, imem_req=0 thereafter;
//      redirect to 0 -> halted=0 and fetch resumes at 0.
//   5. PC wrap with PC_W=8, start at 0xFF -> next imem_addr=0x00.
//   6. rst asserted mid-FETCH with imem_ack arriving one cycle later
//      -> all outputs 0 immediately, ack ignored, pc=RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch/issue stage: owns the PC, reads one word at a time from
// program memory over req/ack and hands opcode/operand to decode over
// valid/ready. Supports PC redirect and a HALT opcode. All outputs are flops.
module inst_fetch #(
  parameter int          INST_W   = 16,
  parameter int          PC_W     = 8,
  parameter int          RESET_PC = 0,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [5:0]        opcode,
  output logic [INST_W-7:0] operand,
  output logic [PC_W-1:0]   pc_out,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              halted
);
  localparam int OPR_W = INST_W - 6;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              req_q, req_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [5:0]        opc_q, opc_d;
  logic [OPR_W-1:0]  opr_q, opr_d;
  logic [PC_W-1:0]   pco_q, pco_d;
  logic              halted_q, halted_d;
  // set when the outstanding read was overtaken by a redirect; its data is dropped
  logic              disc_q, disc_d;

  logic              hs;
  logic              drop_ack;
  logic [PC_W-1:0]   refetch_pc;

  assign hs         = valid_q & inst_ready;
  assign drop_ack   = disc_q | redirect;
  assign refetch_pc = redirect ? redirect_pc : pc_q;

  // State register plus all registered outputs; reset abandons any in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_W'(RESET_PC);
      req_q    <= 1'b0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      opc_q    <= '0;
      opr_q    <= '0;
      pco_q    <= '0;
      halted_q <= 1'b0;
      disc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      opc_q    <= opc_d;
      opr_q    <= opr_d;
      pco_q    <= pco_d;
      halted_q <= halted_d;
      disc_q   <= disc_d;
    end
  end

  // Next-state: redirect beats run, ack and handshake; a dropped ack stays in FETCH
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!redirect && run) state_d = S_FETCH;
      S_FETCH: if (imem_ack && !drop_ack) state_d = S_ISSUE;
      S_ISSUE: begin
        if (redirect)  state_d = S_FETCH;
        else if (hs)   state_d = (opc_q == HALT_OP) ? S_HALT : S_FETCH;
      end
      S_HALT:  if (redirect) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath/output next values for each state
  always_comb begin
    pc_d     = pc_q;
    req_d    = req_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    opc_d    = opc_q;
    opr_d    = opr_q;
    pco_d    = pco_q;
    halted_d = halted_q;
    disc_d   = disc_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (run) begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (drop_ack) begin
            // discard the word and immediately re-request at the target
            pc_d   = refetch_pc;
            addr_d = refetch_pc;
            disc_d = 1'b0;
          end else begin
            req_d   = 1'b0;
            valid_d = 1'b1;
            opc_d   = imem_data[INST_W-1 -: 6];
            opr_d   = imem_data[OPR_W-1:0];
            pco_d   = pc_q;
            pc_d    = pc_q + PC_W'(1);
          end
        end else if (redirect) begin
          // read stays outstanding at the old address; only the target moves
          pc_d   = redirect_pc;
          disc_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (redirect || hs) begin
          valid_d = 1'b0;
          opc_d   = '0;
          opr_d   = '0;
        end
        if (redirect) begin
          pc_d   = redirect_pc;
          req_d  = 1'b1;
          addr_d = redirect_pc;
        end else if (hs) begin
          if (opc_q == HALT_OP) begin
            halted_d = 1'b1;
          end else begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end
        end
      end
      S_HALT: begin
        if (redirect) begin
          halted_d = 1'b0;
          pc_d     = redirect_pc;
          req_d    = 1'b1;
          addr_d   = redirect_pc;
        end
      end
      default: ;
    endcase
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign opcode     = opc_q;
  assign operand    = opr_q;
  assign pc_out     = pco_q;
  assign halted     = halted_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a latency-randomised memory and a stream-level model
// that predicts which PC must be issued next and whether the stage is halted.
module tb_inst_fetch;
  localparam logic [5:0] HALT = 6'b111111;

  logic        clk = 1'b0;
  logic        rst, run, imem_req, imem_ack, inst_valid, inst_ready;
  logic        redirect, halted;
  logic [7:0]  imem_addr, pc_out, redirect_pc;
  logic [15:0] imem_data;
  logic [5:0]  opcode;
  logic [9:0]  operand;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .opcode(opcode), .operand(operand),
    .pc_out(pc_out), .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  int          n_chk = 0, n_pass = 0;
  logic [15:0] mem [256];
  logic [7:0]  exp_pc;
  bit          exp_halt, prev_hold, busy, gap_chk;
  int          cnt, lat_min, lat_max, cyc, last_iss, n_iss;
  logic [7:0]  req_addr;
  bit          rdy, redir;
  logic [7:0]  rpc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    exp_pc = 8'h00; exp_halt = 0; prev_hold = 0; busy = 0; last_iss = -1;
  endtask

  // One clock: check outputs, play memory, drive inputs, advance the model
  task automatic step();
    @(negedge clk);
    cyc++;
    imem_ack  = 1'b0;
    imem_data = 16'($urandom);
    if (prev_hold) chk("hold_valid", inst_valid, 1);
    if (inst_valid) begin
      chk("pc_out", pc_out, exp_pc);
      chk("opcode", opcode, mem[exp_pc][15:10]);
      chk("operand", operand, mem[exp_pc][9:0]);
      chk("req_in_issue", imem_req, 0);
    end else begin
      chk("nop_opcode", opcode, 0);
      chk("nop_operand", operand, 0);
    end
    chk("halted", halted, exp_halt);
    if (exp_halt) chk("req_halted", imem_req, 0);
    if (busy) begin
      chk("addr_stable", imem_addr, req_addr);
      chk("req_held", imem_req, 1);
      cnt--;
      if (cnt == 0) begin
        imem_ack  = 1'b1;
        imem_data = mem[req_addr];
        busy      = 0;
      end
    end else if (imem_req) begin
      chk("req_addr", imem_addr, exp_pc);
      req_addr = imem_addr;
      busy     = 1;
      cnt      = $urandom_range(lat_max, lat_min);
    end
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (inst_valid && inst_ready) begin
      n_iss++;
      if (gap_chk && last_iss >= 0) chk("issue_gap", cyc - last_iss, 3);
      last_iss = cyc;
      if (!redir && opcode == HALT) exp_halt = 1;
      exp_pc = exp_pc + 8'd1;
    end
    prev_hold = inst_valid && !inst_ready && !redir;
    if (redir) begin
      exp_pc   = rpc;
      exp_halt = 0;
    end
  endtask

  initial begin
    rst = 1; run = 0; inst_ready = 0; redirect = 0; redirect_pc = 0;
    imem_ack = 0; imem_data = 0;
    rdy = 1; redir = 0; rpc = 0; gap_chk = 0; cyc = 0; n_iss = 0;
    lat_min = 1; lat_max = 1;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:10] == HALT) mem[i][15] = 1'b0;
    end
    mem[0] = 16'h3800; mem[1] = 16'h0000; mem[2] = 16'h3800; mem[3] = 16'hFC00;

    // reset state
    #12;
    chk("rst_req", imem_req, 0);   chk("rst_addr", imem_addr, 0);
    chk("rst_valid", inst_valid, 0); chk("rst_opcode", opcode, 0);
    chk("rst_pc_out", pc_out, 0);  chk("rst_halted", halted, 0);
    @(negedge clk) rst = 0;

    // basic stream at latency 1 into HALT at pc 3
    gap_chk = 1; run = 1;
    repeat (20) step();
    gap_chk = 0;
    chk("halt_issued", n_iss, 4);
    chk("halt_flag", halted, 1);

    // resume from HALT via redirect to 0, then backpressure
    redir = 1; rpc = 8'h00; step(); redir = 0;
    repeat (4) step();
    lat_min = 2; lat_max = 2; rdy = 0;
    repeat (9) step();
    rdy = 1; step();

    // redirect to 0x40 while the read of 0x05 is outstanding (latency 4)
    lat_min = 4; lat_max = 4;
    redir = 1; rpc = 8'h05; step(); redir = 0;
    for (int i = 0; i < 20 && !(busy && req_addr == 8'h05 && cnt < 4); i++) step();
    chk("read5_outstanding", {busy, req_addr}, {1'b1, 8'h05});
    redir = 1; rpc = 8'h40; step(); redir = 0;
    repeat (16) step();

    // PC wrap 0xFF -> 0x00
    lat_min = 1; lat_max = 1;
    redir = 1; rpc = 8'hFF; step(); redir = 0;
    repeat (8) step();

    // reset mid-FETCH, ack arrives one cycle later and must be ignored
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && !busy; i++) step();
    chk("busy_before_rst", busy, 1);
    #2 rst = 1; run = 0;
    #1;
    chk("arst_req", imem_req, 0);     chk("arst_addr", imem_addr, 0);
    chk("arst_valid", inst_valid, 0); chk("arst_opcode", opcode, 0);
    chk("arst_operand", operand, 0);  chk("arst_pc_out", pc_out, 0);
    chk("arst_halted", halted, 0);
    model_reset();
    @(negedge clk);
    rst = 0; imem_ack = 1; imem_data = 16'h1234;
    repeat (3) step();
    chk("late_ack_req", imem_req, 0);
    chk("late_ack_valid", inst_valid, 0);
    run = 1;
    repeat (12) step();

    // randomized traffic
    lat_min = 1; lat_max = 4;
    mem[8'h10] = {HALT, 10'h011}; mem[8'h80] = {HALT, 10'h2A5}; mem[8'hC3] = {HALT, 10'h000};
    n_iss = 0;
    repeat (3000) begin
      rdy   = ($urandom_range(9, 0) < 7);
      redir = ($urandom_range(15, 0) == 0);
      rpc   = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
      step();
    end
    chk("random_progress", n_iss > 100, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
